// File: rtl/spw_axi_intr_ctrl.sv
`default_nettype none
// spw_axi_intr_ctrl: AXI4-Lite interrupt controller aggregating SpaceWire event lines into irq.
// Revision 1.0 - initial release
module spw_axi_intr_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 4,
  parameter bit C_IRQ_ACTIVE_HIGH  = 1'b1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  localparam int N = C_NUM_OF_INTR;
  localparam logic [2:0] A_GIE = 3'd0;
  localparam logic [2:0] A_IER = 3'd1;
  localparam logic [2:0] A_ISR = 3'd2;
  localparam logic [2:0] A_IAR = 3'd3;
  localparam logic [2:0] A_IPR = 3'd4;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic                          out_of_reset;
  logic                          wr_hs;
  logic                          rd_hs;
  logic                          wr_en;
  logic [2:0]                    wsel;
  logic                          gie;
  logic [N-1:0]                  ier;
  logic [N-1:0]                  isr;
  logic [N-1:0]                  src_q;
  logic [N-1:0]                  src_rise;
  logic [N-1:0]                  ack;
  logic [N-1:0]                  ipr;
  logic                          irq_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                          unused_bits;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) out_of_reset <= 1'b0;
    else          out_of_reset <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
    end
  end

  always_comb begin
    wstate_nxt    = wstate;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    wr_hs         = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (out_of_reset && S_AXI_AWVALID && S_AXI_WVALID) begin
          S_AXI_AWREADY = 1'b1;
          S_AXI_WREADY  = 1'b1;
          wr_hs         = 1'b1;
          wstate_nxt    = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt    = rstate;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    rd_hs         = 1'b0;
    case (rstate)
      R_IDLE: begin
        S_AXI_ARREADY = out_of_reset;
        if (out_of_reset && S_AXI_ARVALID) begin
          rd_hs      = 1'b1;
          rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign wr_en    = wr_hs && S_AXI_WSTRB[0];
  assign wsel     = S_AXI_AWADDR[4:2];
  assign src_rise = intr_src & ~src_q;
  assign ack      = (wr_en && (wsel == A_IAR)) ? S_AXI_WDATA[N-1:0] : '0;
  assign ipr      = isr & ier;

  // A new edge overrides a simultaneous acknowledge of the same bit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gie   <= 1'b0;
      ier   <= '0;
      isr   <= '0;
      src_q <= '0;
      irq_q <= 1'b0;
    end else begin
      src_q <= intr_src;
      isr   <= (isr & ~ack) | src_rise;
      irq_q <= gie && (ipr != '0);
      if (wr_en && (wsel == A_GIE)) gie <= S_AXI_WDATA[0];
      if (wr_en && (wsel == A_IER)) ier <= S_AXI_WDATA[N-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[4:2])
      A_GIE:   rd_word[0]     = gie;
      A_IER:   rd_word[N-1:0] = ier;
      A_ISR:   rd_word[N-1:0] = isr;
      A_IPR:   rd_word[N-1:0] = ipr;
      default: rd_word        = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)   S_AXI_RDATA <= '0;
    else if (rd_hs) S_AXI_RDATA <= rd_word;
  end

  assign irq = C_IRQ_ACTIVE_HIGH ? irq_q : ~irq_q;

  assign unused_bits = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

endmodule
`default_nettype wire
